// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - UART byte stream in, instruction-memory write port out
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wr_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wr_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles UART download frames into instruction-memory word writes
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus,
    output logic          core_hold,
    output logic          done,
    output logic          error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [31:0] len_q;
    logic [31:0] word_q;
    logic [31:0] word_idx_q;
    logic [31:0] len_full, word_full;
    logic        start, len_byte, data_byte, word_done, set_done, set_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        core_hold = (state_q != S_IDLE);
        start     = 1'b0;
        len_byte  = 1'b0;
        data_byte = 1'b0;
        word_done = 1'b0;
        set_done  = 1'b0;
        set_error = 1'b0;
        len_full  = {bus.rx_data, len_q[23:0]};
        word_full = {bus.rx_data, word_q[23:0]};
        if (bus.rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        start   = 1'b1;
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    len_byte = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d  = S_IDLE;
                            set_done = 1'b1;
`endif
                        end else if (len_full > MAX_WORDS) begin
                            state_d   = S_IDLE;
                            set_error = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    data_byte = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        word_done = 1'b1;
                        if (word_idx_q == len_q - 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d  = S_IDLE;
                            set_done = 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    state_d = S_IDLE;
                    if (bus.rx_data == xor_q) set_done  = 1'b1;
                    else                      set_error = 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The write is registered, so the final word's we pulse lands in the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.imem_we      <= 1'b0;
            bus.imem_addr    <= BASE_ADDR;
            bus.imem_wr_data <= 32'd0;
            done             <= 1'b0;
            error            <= 1'b0;
            byte_cnt_q       <= 2'd0;
            len_q            <= 32'd0;
            word_q           <= 32'd0;
            word_idx_q       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q            <= 8'd0;
`endif
        end else begin
            bus.imem_we <= word_done;
            if (start) begin
                done       <= 1'b0;
                error      <= 1'b0;
                byte_cnt_q <= 2'd0;
                len_q      <= 32'd0;
                word_q     <= 32'd0;
                word_idx_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q      <= 8'd0;
`endif
            end
            if (len_byte) begin
                len_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_data;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (data_byte) begin
                word_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_data;
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q      <= xor_q ^ bus.rx_data;
`endif
            end
            if (word_done) begin
                bus.imem_addr    <= BASE_ADDR + (word_idx_q << 2);
                bus.imem_wr_data <= word_full;
                word_idx_q       <= word_idx_q + 32'd1;
            end
            if (set_done)  done  <= 1'b1;
            if (set_error) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed frames against imem_loader with immediate-assertion checks
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst;
    logic core_hold, done, error;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader_if bus_if();

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus_if.imem_we === 1'b1) begin
            wa.push_back(bus_if.imem_addr);
            wd.push_back(bus_if.imem_wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8]);
            idle(gap);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        idle(3);
        chk("rst_we", 32'(bus_if.imem_we), 32'd0);
        chk("rst_addr", bus_if.imem_addr, 32'h0);
        chk("rst_data", bus_if.imem_wr_data, 32'h0);
        chk("rst_hold", 32'(core_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        idle(1);

        // Two words back to back
        send(8'hA5);
        chk("t1_hold_after_sync", 32'(core_hold), 32'd1);
        send_word(32'd2, 0);
        send(8'h13); send(8'h00); send(8'h00);
        chk("t1_no_we_early", 32'(bus_if.imem_we), 32'd0);
        send(8'h00);
        chk("t1_w0_we", 32'(bus_if.imem_we), 32'd1);
        chk("t1_w0_addr", bus_if.imem_addr, 32'h0);
        chk("t1_w0_data", bus_if.imem_wr_data, 32'h0000_0013);
        send(8'h93);
        chk("t1_we_pulse", 32'(bus_if.imem_we), 32'd0);
        send(8'h00); send(8'h10); send(8'h00);
        chk("t1_w1_we", 32'(bus_if.imem_we), 32'd1);
        chk("t1_w1_addr", bus_if.imem_addr, 32'h4);
        chk("t1_w1_data", bus_if.imem_wr_data, 32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t1_hold_chk", 32'(core_hold), 32'd1);
        send(8'h90);
`endif
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_hold_end", 32'(core_hold), 32'd0);
        chk("t1_nwr", 32'(wa.size()), 32'd2);
        idle(1);
        chk("t1_we_low", 32'(bus_if.imem_we), 32'd0);
        chk("t1_addr_hold", bus_if.imem_addr, 32'h4);

        // Same frame with 0..5 idle cycles between strobes
        wa.delete(); wd.delete();
        send(8'hA5); idle(3);
        send(8'h02); idle(0); send(8'h00); idle(5); send(8'h00); idle(1); send(8'h00); idle(2);
        send(8'h13); idle(4); send(8'h00); idle(0); send(8'h00); idle(3); send(8'h00); idle(5);
        send(8'h93); idle(1); send(8'h00); idle(2); send(8'h10); idle(0); send(8'h00); idle(4);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h90);
`endif
        chk("t5_nwr", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("t5_a0", wa[0], 32'h0);
            chk("t5_d0", wd[0], 32'h0000_0013);
            chk("t5_a1", wa[1], 32'h4);
            chk("t5_d1", wd[1], 32'h0010_0093);
        end
        chk("t5_done", 32'(done), 32'd1);

        // Noise ignored, zero-length frame
        wa.delete(); wd.delete();
        send(8'h00); send(8'h7F);
        chk("t2_idle_hold", 32'(core_hold), 32'd0);
        send(8'hA5);
        chk("t2_done_cleared", 32'(done), 32'd0);
        send_word(32'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t2_done_wait", 32'(done), 32'd0);
        send(8'h00);
`endif
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_hold", 32'(core_hold), 32'd0);
        chk("t2_nwr", 32'(wa.size()), 32'd0);

        // Length over the limit
        send(8'hA5);
        send_word(32'd16385, 0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_hold", 32'(core_hold), 32'd0);
        chk("t3_nwr", 32'(wa.size()), 32'd0);

        // Length exactly at the limit is accepted
        send(8'hA5);
        send_word(32'd16384, 0);
        chk("t3b_hold", 32'(core_hold), 32'd1);
        chk("t3b_error", 32'(error), 32'd0);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("t3b_rst_hold", 32'(core_hold), 32'd0);
        chk("t3b_rst_addr", bus_if.imem_addr, 32'h0);
        chk("t3b_rst_data", bus_if.imem_wr_data, 32'h0);

        // Reset mid-word, then a clean reload
        send(8'hA5);
        send_word(32'd1, 0);
        send(8'hEF); send(8'hBE);
        rst = 1'b1; idle(1); rst = 1'b0;
        send(8'hAD); send(8'hDE);
        chk("t4_we", 32'(bus_if.imem_we), 32'd0);
        chk("t4_hold", 32'(core_hold), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_error", 32'(error), 32'd0);
        chk("t4_nwr", 32'(wa.size()), 32'd0);
        send(8'hA5);
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        chk("t4_rl_we", 32'(bus_if.imem_we), 32'd1);
        chk("t4_rl_addr", bus_if.imem_addr, 32'h0);
        chk("t4_rl_data", bus_if.imem_wr_data, 32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h22);
`endif
        chk("t4_rl_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum accept and reject
        send(8'hA5);
        send_word(32'd1, 0);
        send_word(32'h4433_2211, 0);
        send(8'h44);
        chk("t6_ok_done", 32'(done), 32'd1);
        chk("t6_ok_error", 32'(error), 32'd0);
        wa.delete(); wd.delete();
        send(8'hA5);
        send_word(32'd1, 0);
        send_word(32'h4433_2211, 0);
        send(8'h00);
        chk("t6_bad_error", 32'(error), 32'd1);
        chk("t6_bad_done", 32'(done), 32'd0);
        chk("t6_bad_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("t6_bad_addr", wa[0], 32'h0);
            chk("t6_bad_data", wd[0], 32'h4433_2211);
        end
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
